dmem_arbiter: RTL and testbench



---
 rtl/dmem_arb_pkg.sv | 26 ++
 rtl/dmem_arbiter_rr_pick.sv | 39 +++
 rtl/dmem_arbiter.sv | 157 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// ============================================================================
//  Module      : dmem_arb_pkg
//  Description : Shared constants for the data-memory arbiter: FSM encoding,
//                default geometry and index-width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_arb_pkg;

  localparam int DEF_NUM_CORES = 4;
  localparam int DEF_ADDR_W    = 8;
  localparam int DEF_DATA_W    = 8;
  localparam int CORE_IDX_W    = $clog2(DEF_NUM_CORES);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_arbiter_rr_pick.sv
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin selector: first set request bit at
//                or after ptr_i, wrapping from NUM_CORES-1 back to 0.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick
  import dmem_arb_pkg::*;
#(
  parameter int NUM_CORES = DEF_NUM_CORES,
  parameter int IDX_W     = idx_width(NUM_CORES)
) (
  input  logic [NUM_CORES-1:0] req_i,
  input  logic [IDX_W-1:0]     ptr_i,
  output logic                 found_o,
  output logic [IDX_W-1:0]     idx_o
);

  logic [IDX_W-1:0] cand;

  // Scan farthest-first so the nearest requester at/after ptr_i wins last.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    cand    = '0;
    for (int k = NUM_CORES - 1; k >= 0; k--) begin
      cand = IDX_W'((int'(ptr_i) + k) % NUM_CORES);
      if (req_i[cand]) begin
        found_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
//  Module      : dmem_arbiter
//  Description : Round-robin arbiter giving NUM_CORES cores 3-cycle access to
//                one synchronous data RAM. Optional macro DMEM_ARB_LOCK_EN
//                adds core_lock for atomic read-modify-write sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int NUM_CORES = DEF_NUM_CORES,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W
) (
  input  logic                        CLK,
  input  logic                        RSTn,
  input  logic [NUM_CORES-1:0]        core_req,
  input  logic [NUM_CORES-1:0]        core_we,
  input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
  input  logic [NUM_CORES*DATA_W-1:0] core_wdata,
`ifdef DMEM_ARB_LOCK_EN
  input  logic [NUM_CORES-1:0]        core_lock,
`endif
  output logic [NUM_CORES-1:0]        core_ack,
  output logic [NUM_CORES*DATA_W-1:0] core_rdata,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  output logic                        mem_we,
  input  logic [DATA_W-1:0]           mem_rdata
);

  localparam int               IDX_W    = idx_width(NUM_CORES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CORES - 1);

  logic [1:0]                  state_q, state_d;
  logic                        pick_found;
  logic [IDX_W-1:0]            pick_idx;
  logic                        grant_ok;
  logic [IDX_W-1:0]            winner_q;
  logic [IDX_W-1:0]            rr_ptr_q, rr_ptr_d;
  logic                        txn_we_q;
  logic                        mem_we_q;
  logic [ADDR_W-1:0]           mem_addr_q;
  logic [DATA_W-1:0]           mem_wdata_q;
  logic [NUM_CORES*DATA_W-1:0] core_rdata_q;

  rr_pick #(
    .NUM_CORES (NUM_CORES),
    .IDX_W     (IDX_W)
  ) u_rr_pick (
    .req_i   (core_req),
    .ptr_i   (rr_ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

`ifdef DMEM_ARB_LOCK_EN
  logic lock_hold_q;

  // While holding, the scan starts at the locked core, so any other pick means it is not requesting.
  assign grant_ok = pick_found && (!lock_hold_q || (pick_idx == rr_ptr_q));

  always_comb begin
    if (core_lock[winner_q]) begin
      rr_ptr_d = winner_q;
    end else begin
      rr_ptr_d = (winner_q == LAST_IDX) ? '0 : winner_q + IDX_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      lock_hold_q <= 1'b0;
    end else if (state_q == RESP) begin
      lock_hold_q <= core_lock[winner_q];
    end
  end
`else
  assign grant_ok = pick_found;

  always_comb begin
    rr_ptr_d = (winner_q == LAST_IDX) ? '0 : winner_q + IDX_W'(1);
  end
`endif

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_ok) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    core_ack = '0;
    if (state_q == RESP) begin
      core_ack[winner_q] = 1'b1;
    end
  end

  // Request fields are captured once at grant; later changes by the core are ignored.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      winner_q     <= '0;
      rr_ptr_q     <= '0;
      txn_we_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      core_rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_ok) begin
            winner_q    <= pick_idx;
            txn_we_q    <= core_we[pick_idx];
            mem_we_q    <= core_we[pick_idx];
            mem_addr_q  <= core_addr[pick_idx*ADDR_W +: ADDR_W];
            mem_wdata_q <= core_wdata[pick_idx*DATA_W +: DATA_W];
          end
        end
        ACCESS: begin
          mem_we_q <= 1'b0;
        end
        RESP: begin
          if (!txn_we_q) begin
            core_rdata_q[winner_q*DATA_W +: DATA_W] <= mem_rdata;
          end
          rr_ptr_q <= rr_ptr_d;
        end
        default: begin
          mem_we_q <= 1'b0;
        end
      endcase
    end
  end

  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign core_rdata = core_rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
//  Module      : tb_dmem_arbiter
//  Description : Self-checking bench for dmem_arbiter with a synchronous RAM
//                model; lock sequence compiled when DMEM_ARB_LOCK_EN is set.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_arbiter;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req, we;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
`ifdef DMEM_ARB_LOCK_EN
  logic [N-1:0]    lock;
`endif
  logic [N-1:0]    core_ack;
  logic [N*DW-1:0] core_rdata;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic            mem_we;
  logic [DW-1:0]   mem_rdata;

  logic [DW-1:0]   ram [256];
  logic            ram_init;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .CLK        (clk),
    .RSTn       (rst_n),
    .core_req   (req),
    .core_we    (we),
    .core_addr  (addr),
    .core_wdata (wdata),
`ifdef DMEM_ARB_LOCK_EN
    .core_lock  (lock),
`endif
    .core_ack   (core_ack),
    .core_rdata (core_rdata),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata)
  );

  function automatic logic [7:0] init_val(input logic [7:0] a);
    return (a == 8'h10) ? 8'hA5 : (a ^ 8'h5A);
  endfunction

  // Synchronous single-port RAM: data valid one cycle after the address.
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_val(8'(i));
    end else if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
    end
    mem_rdata <= ram[mem_addr];
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] slot(input int c);
    return core_rdata[c*DW +: DW];
  endfunction

  task automatic set_core(input int c, input logic r, input logic w,
                          input logic [7:0] a, input logic [7:0] d);
    req[c]            = r;
    we[c]             = w;
    addr[c*AW +: AW]  = a;
    wdata[c*DW +: DW] = d;
  endtask

  task automatic do_reset(input logic init);
    req = '0; we = '0; addr = '0; wdata = '0;
`ifdef DMEM_ARB_LOCK_EN
    lock = '0;
`endif
    rst_n    = 1'b0;
    ram_init = init;
    repeat (2) @(negedge clk);
    ram_init = 1'b0;
    rst_n    = 1'b1;
  endtask

  // Single uncontended transaction; the call starts in an IDLE cycle (cycle 0).
  task automatic run_single(input string tag, input int c, input logic w,
                            input logic [7:0] a, input logic [7:0] d, input logic [7:0] exp_rd);
    set_core(c, 1'b1, w, a, d);
    @(negedge clk);
    check({tag, " mem_we@1"},   32'(mem_we),   32'(w));
    check({tag, " mem_addr@1"}, 32'(mem_addr), 32'(a));
    if (w) check({tag, " mem_wdata@1"}, 32'(mem_wdata), 32'(d));
    check({tag, " ack@1"}, 32'(core_ack), 32'(0));
    @(negedge clk);
    check({tag, " ack@2"},    32'(core_ack), 32'(1) << c);
    check({tag, " mem_we@2"}, 32'(mem_we),   32'(0));
    req[c] = 1'b0;
    @(negedge clk);
    check({tag, " ack@3"}, 32'(core_ack), 32'(0));
    if (!w) check({tag, " rdata"}, 32'(slot(c)), 32'(exp_rd));
  endtask

  typedef struct {
    int         core;
    logic       we;
    logic [7:0] a;
    logic [7:0] d;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t vt[6];

  logic [N-1:0]    exp_ack;
  logic            exp_we;
  logic [N*DW-1:0] exp_vec;
  logic [7:0]      ref_mem [256];
  logic [7:0]      exp_rd [N];
  int              raise_cyc [N];
  int              ptr_m, g_core, g_cycle, next_free, just;
  logic            active, got, g_we;
  logic [7:0]      g_addr, g_wdata, g_rdata;

  initial begin
    vt[0] = '{1, 1'b0, 8'h10, 8'h00, 8'hA5};
    vt[1] = '{2, 1'b1, 8'h20, 8'h3C, 8'h00};
    vt[2] = '{0, 1'b0, 8'h20, 8'h00, 8'h3C};
    vt[3] = '{3, 1'b1, 8'hFF, 8'h81, 8'h00};
    vt[4] = '{3, 1'b0, 8'hFF, 8'h00, 8'h81};
    vt[5] = '{1, 1'b0, 8'h00, 8'h00, 8'h5A};

    do_reset(1'b1);
    check("reset core_ack",   32'(core_ack),   32'(0));
    check("reset core_rdata", 32'(core_rdata), 32'(0));
    check("reset mem_addr",   32'(mem_addr),   32'(0));
    check("reset mem_wdata",  32'(mem_wdata),  32'(0));
    check("reset mem_we",     32'(mem_we),     32'(0));

    for (int k = 0; k < 6; k++)
      run_single($sformatf("vec%0d", k), vt[k].core, vt[k].we, vt[k].a, vt[k].d, vt[k].exp_rd);

    // Contention from reset: grant order 0,1,2,3 then core0 again.
    do_reset(1'b0);
    for (int c = 0; c < N; c++) set_core(c, 1'b1, 1'b0, 8'(8'h40 + c), 8'h00);
    for (int c = 0; c < 16; c++) begin
      exp_ack = (c == 2)  ? 4'b0001 : (c == 5)  ? 4'b0010 : (c == 8) ? 4'b0100 :
                (c == 11) ? 4'b1000 : (c == 14) ? 4'b0001 : 4'b0000;
      check($sformatf("contend ack c%0d", c), 32'(core_ack), 32'(exp_ack));
      if (c == 3) check("contend rdata0 first", 32'(slot(0)), 32'(init_val(8'h40)));
      req = req & ~exp_ack;
      if (c == 3) set_core(0, 1'b1, 1'b0, 8'h50, 8'h00);
      @(negedge clk);
    end
    check("contend rdata0", 32'(slot(0)), 32'(init_val(8'h50)));
    for (int c = 1; c < N; c++)
      check($sformatf("contend rdata%0d", c), 32'(slot(c)), 32'(init_val(8'(8'h40 + c))));

    // Wrap: after core3 completes the pointer is 0, so core0 beats core3.
    run_single("pre-wrap", 3, 1'b0, 8'h33, 8'h00, init_val(8'h33));
    set_core(0, 1'b1, 1'b0, 8'h60, 8'h00);
    set_core(3, 1'b1, 1'b0, 8'h63, 8'h00);
    for (int c = 0; c < 7; c++) begin
      exp_ack = (c == 2) ? 4'b0001 : (c == 5) ? 4'b1000 : 4'b0000;
      check($sformatf("wrap ack c%0d", c), 32'(core_ack), 32'(exp_ack));
      req = req & ~exp_ack;
      @(negedge clk);
    end

    // Reset during the ACCESS cycle of a write.
    run_single("pre-rst", 1, 1'b0, 8'h11, 8'h00, init_val(8'h11));
    set_core(2, 1'b1, 1'b1, 8'h30, 8'h77);
    @(negedge clk);
    check("midrst mem_we before", 32'(mem_we), 32'(1));
    #1 rst_n = 1'b0;
    #1;
    check("midrst mem_we async", 32'(mem_we),   32'(0));
    check("midrst ack",          32'(core_ack), 32'(0));
    req = '0;
    @(negedge clk);
    check("midrst ack held", 32'(core_ack), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst no write", 32'(ram[8'h30]), 32'(init_val(8'h30)));
    set_core(1, 1'b1, 1'b0, 8'h21, 8'h00);
    set_core(3, 1'b1, 1'b0, 8'h23, 8'h00);
    for (int c = 0; c < 7; c++) begin
      exp_ack = (c == 2) ? 4'b0010 : (c == 5) ? 4'b1000 : 4'b0000;
      check($sformatf("postrst ack c%0d", c), 32'(core_ack), 32'(exp_ack));
      req = req & ~exp_ack;
      @(negedge clk);
    end

`ifdef DMEM_ARB_LOCK_EN
    // Locked read then write by core0 must finish before core1 is served.
    set_core(0, 1'b1, 1'b0, 8'h70, 8'h00);
    set_core(1, 1'b1, 1'b0, 8'h71, 8'h00);
    lock[0] = 1'b1;
    for (int c = 0; c < 12; c++) begin
      exp_ack = (c == 2 || c == 7) ? 4'b0001 : (c == 10) ? 4'b0010 : 4'b0000;
      check($sformatf("lock ack c%0d", c), 32'(core_ack), 32'(exp_ack));
      if (c == 6) check("lock write mem_we", 32'(mem_we), 32'(1));
      req = req & ~exp_ack;
      if (c == 3) lock[0] = 1'b0;
      if (c == 5) set_core(0, 1'b1, 1'b1, 8'h70, 8'hC3);
      @(negedge clk);
    end
    check("lock rmw result", 32'(ram[8'h70]), 32'(8'hC3));
`endif

    // Randomised traffic against a transaction-level model.
    do_reset(1'b1);
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(8'(i));
    for (int i = 0; i < N; i++) begin exp_rd[i] = '0; raise_cyc[i] = 0; end
    ptr_m = 0; active = 1'b0; next_free = 0; g_core = 0; g_cycle = 0;
    g_we = 1'b0; g_addr = '0; g_wdata = '0; g_rdata = '0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      exp_ack = '0;
      exp_we  = 1'b0;
      if (active && cyc == g_cycle + 2) exp_ack[g_core] = 1'b1;
      if (active && cyc == g_cycle + 1) exp_we = g_we;
      check("rnd ack",    32'(core_ack), 32'(exp_ack));
      check("rnd mem_we", 32'(mem_we),   32'(exp_we));
      if (active && cyc == g_cycle + 1) begin
        check("rnd mem_addr", 32'(mem_addr), 32'(g_addr));
        if (g_we) check("rnd mem_wdata", 32'(mem_wdata), 32'(g_wdata));
      end
      for (int i = 0; i < N; i++) exp_vec[i*DW +: DW] = exp_rd[i];
      check("rnd core_rdata", 32'(core_rdata), 32'(exp_vec));
      just = -1;
      if (exp_ack != '0) begin
        check("rnd wait bound", 32'((cyc - raise_cyc[g_core]) <= 3 * N), 32'(1));
        if (!g_we) exp_rd[g_core] = g_rdata;
        ptr_m     = (g_core + 1) % N;
        req[g_core] = 1'b0;
        active    = 1'b0;
        next_free = cyc + 1;
        just      = g_core;
      end
      for (int i = 0; i < N; i++) begin
        if (!req[i] && i != just) begin
          if ($urandom_range(0, 2) == 0) begin
            set_core(i, 1'b1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom));
            raise_cyc[i] = cyc;
          end
        end else if (req[i] && active && i == g_core && cyc > g_cycle && $urandom_range(0, 1) == 1) begin
          addr[i*AW +: AW]  = 8'($urandom);
          wdata[i*DW +: DW] = 8'($urandom);
          we[i]             = ~we[i];
        end
      end
      if (!active && cyc >= next_free && req != '0) begin
        got = 1'b0;
        for (int k = 0; k < N; k++) begin
          if (!got && req[(ptr_m + k) % N]) begin
            g_core = (ptr_m + k) % N;
            got    = 1'b1;
          end
        end
        g_we    = we[g_core];
        g_addr  = addr[g_core*AW +: AW];
        g_wdata = wdata[g_core*DW +: DW];
        if (g_we) ref_mem[g_addr] = g_wdata;
        else      g_rdata = ref_mem[g_addr];
        active  = 1'b1;
        g_cycle = cyc;
      end
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
